vga_sync_rx: RTL and testbench
==============================

// Module: vga_sync_rx
// PURPOSE
//  Receive end of the VGA timing interface. Takes the active-high hs/vs pulses from the timing generator and recovers hpixel/vpixel.
//  Checks line length, frame length and pulse widths against nominal timing, then reports lock.
//  Sits beside the display path as the on-chip timing monitor/regenerator.
// PARAMETERS
//  H_TOTAL     800  clocks per line (10-bit counters; must be <= 1024)
//  V_TOTAL     521  lines per frame
//  H_PULSE     96   hs high width, clocks
//  V_PULSE     2    vs high width, counted in line starts while vs high
//  LOCK_FRAMES 2    consecutive error-free frames needed to reach LOCKED
// PORTS
//  clk_25      in   1   pixel clock, same domain as hs/vs source
//  rst_n       in   1   asynchronous active-low reset
//  hs          in   1   horizontal sync, active high
//  vs          in   1   vertical sync, active high
//  h_pos       out  10  recovered horizontal position
//  v_pos       out  10  recovered line number
//  line_start  out  1   1-cycle pulse when h_pos becomes 0
//  frame_start out  1   1-cycle pulse when h_pos and v_pos both become 0
//  sync_err    out  1   1-cycle pulse on any timing violation
//  err_cnt     out  8   saturating count of sync_err pulses
//  locked      out  1   high in LOCKED state
// BEHAVIOUR
//  Reset: all outputs 0, state SEARCH. Reset is asynchronous and takes effect immediately, including mid-frame.
//  Inputs are registered once; an edge is the registered value differing from its previous registered value.
//  Latency: a rising hs edge sampled at cycle t gives h_pos=0 and line_start=1 at t+2. h_pos then increments by 1 per clock.
//  Flywheel: when h_pos = H_TOTAL-1 and no hs edge arrives, h_pos wraps to 0 and line_start pulses. This is a missing-hs error.
//  hs edge when h_pos != H_TOTAL-1 (after first line): early-hs error; h_pos realigns to 0.
//  hs falling edge when h_pos != H_PULSE-1: hs-width error.
//  v_pos increments on each line_start and wraps V_TOTAL-1 -> 0.
//  A vs rising edge arms a realign. The next line_start sets v_pos=0 and pulses frame_start.
//  If the vs edge and the hs edge fall in the same cycle, that line_start is the frame start.
//  Realign while v_pos != V_TOTAL-1: frame-length error.
//  Line starts counted while vs is high must equal V_PULSE at the vs falling edge; otherwise vs-width error.
//  Several errors in the same cycle produce one sync_err pulse, and err_cnt increments by 1. err_cnt holds at 255.
//  FSM SEARCH -> ACQUIRE: on the first frame_start; the good-frame counter is cleared.
//  FSM ACQUIRE: each frame_start with no error since the previous one increments the good-frame counter.
//  FSM ACQUIRE -> LOCKED: when the good-frame counter reaches LOCK_FRAMES.
//  FSM ACQUIRE -> SEARCH: on any error.
//  FSM LOCKED -> SEARCH: on any sync_err. locked falls in the same cycle sync_err is high.
//  In SEARCH, h_pos and v_pos still free-run on the flywheel, but errors are neither flagged nor counted.
//  Flagging and counting resume after the first frame_start.
// STRUCTURE
//  vga_timing_pkg holds shared constants and types:
//   - H_TOTAL, V_TOTAL, H_PULSE and V_PULSE defaults, shared with the timing generator
//   - the state enum {SEARCH, ACQUIRE, LOCKED}
//  sync_edge_det sub-module: input register plus rise/fall pulse outputs, instantiated once for hs and once for vs.
//  Top level holds the h/v counters, error logic, FSM and err_cnt.
// TESTING
//  1 Drive nominal timing (800x521, hs 96, vs 2 lines) from reset:
//    - h_pos=0 two cycles after each hs rise
//    - locked=1 at the 3rd frame_start
//    - sync_err never pulses
//  2 While locked, shorten one line to 799 clocks: one sync_err, err_cnt=1, locked=0, locked=1 again two frames later.
//  3 While locked, suppress one hs pulse: h_pos wraps 799->0 on its own, one sync_err, v_pos still advances by 1.
//  4 While locked, widen vs to 3 lines: sync_err at the vs fall, locked=0.
//  5 Assert rst_n=0 at h_pos=400, v_pos=200: all outputs 0 with no clock edge; relock after two clean frames.
//  6 Drive 300 corrupted lines after the first frame_start: err_cnt stops at 255 and does not wrap.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and types, used by the timing generator and
// by the receive-side monitor (vga_sync_rx).
//  - nominal 640x480@60 line/frame geometry and sync pulse widths
//  - sync_state_e: lock FSM states
package vga_timing_pkg;
  localparam int H_TOTAL_DEF     = 800;
  localparam int V_TOTAL_DEF     = 521;
  localparam int H_PULSE_DEF     = 96;
  localparam int V_PULSE_DEF     = 2;
  localparam int LOCK_FRAMES_DEF = 2;

  localparam int POS_W = 10;  // h/v counter width, H_TOTAL must fit
  localparam int ERR_W = 8;   // saturating error counter width

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [ERR_W-1:0] err_cnt_t;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} sync_state_e;
endpackage

// File: rtl/vga_sync_rx_if.sv
// Timing bus between a VGA sync source and the receive-side monitor.
//  master: drives hs/vs, observes recovered position and status
//  slave : consumes hs/vs, produces h_pos, v_pos, line_start, frame_start,
//          sync_err, err_cnt, locked
interface vga_sync_rx_if;
  import vga_timing_pkg::*;
  logic     hs;
  logic     vs;
  pos_t     h_pos;
  pos_t     v_pos;
  logic     line_start;
  logic     frame_start;
  logic     sync_err;
  err_cnt_t err_cnt;
  logic     locked;

  modport master (output hs, vs,
                  input  h_pos, v_pos, line_start, frame_start, sync_err, err_cnt, locked);
  modport slave  (input  hs, vs,
                  output h_pos, v_pos, line_start, frame_start, sync_err, err_cnt, locked);
endinterface

// File: rtl/vga_sync_rx_edge_det.sv
// sync_edge_det: registers one sync input and reports its edges.
//  clk_25, rst_n : clock, async active-low reset
//  d             : raw sync input
//  rise, fall    : combinational pulses, registered value vs previous one
module sync_edge_det (
  input  logic clk_25,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic d_q, d_qq;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      d_q  <= 1'b0;
      d_qq <= 1'b0;
    end else begin
      d_q  <= d;
      d_qq <= d_q;
    end
  end

  assign rise =  d_q & ~d_qq;
  assign fall = ~d_q &  d_qq;
endmodule

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers h/v position from active-high hs/vs, checks line
// length, frame length and pulse widths, and reports lock.
//  clk_25 : pixel clock, same domain as the hs/vs source
//  rst_n  : async active-low reset
//  bus    : slave side of vga_sync_rx_if (hs/vs in; position/status out)
module vga_sync_rx
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int H_PULSE     = H_PULSE_DEF,
  parameter int V_PULSE     = V_PULSE_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic          clk_25,
  input  logic          rst_n,
  vga_sync_rx_if.slave  bus
);
  localparam pos_t     H_LAST  = pos_t'(H_TOTAL - 1);
  localparam pos_t     V_LAST  = pos_t'(V_TOTAL - 1);
  localparam pos_t     H_PW    = pos_t'(H_PULSE - 1);
  localparam pos_t     V_PW    = pos_t'(V_PULSE);
  localparam err_cnt_t ERR_MAX = '1;
  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

  logic hs_rise, hs_fall, vs_rise, vs_fall;

  sync_edge_det u_hs_det (.clk_25(clk_25), .rst_n(rst_n), .d(bus.hs), .rise(hs_rise), .fall(hs_fall));
  sync_edge_det u_vs_det (.clk_25(clk_25), .rst_n(rst_n), .d(bus.vs), .rise(vs_rise), .fall(vs_fall));

  pos_t        h_pos_q, v_pos_q, vs_lines;
  logic        vs_hi, armed, flag_en;
  logic        line_start_q, frame_start_q, sync_err_q, locked_q;
  err_cnt_t    err_cnt_q;
  sync_state_e state, state_nx;
  logic [7:0]  good_cnt, good_nx;

  logic h_end, v_end, vs_lvl, ls_c, realign_c;
  logic err_early, err_miss, err_hw, err_frame, err_vw, err_c;

  // vs_hi lags the registered vs by one clock; rebuild the registered level
  // from it so a vs rise on the same clock as a line start counts that line.
  assign vs_lvl    = vs_rise | (vs_hi & ~vs_fall);

  assign h_end     = (h_pos_q == H_LAST);
  assign v_end     = (v_pos_q == V_LAST);
  assign ls_c      = hs_rise | h_end;             // hs edge or flywheel wrap
  assign realign_c = ls_c & (armed | vs_rise);    // vs+hs together frame here

  assign err_early = hs_rise & ~h_end;
  assign err_miss  = h_end & ~hs_rise;
  assign err_hw    = hs_fall & (h_pos_q != H_PW);
  assign err_frame = realign_c & ~v_end;
  assign err_vw    = vs_fall & (vs_lines != V_PW);
  // Nothing is flagged until the first frame_start since reset.
  assign err_c     = flag_en & (err_early | err_miss | err_hw | err_frame | err_vw);

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      h_pos_q       <= '0;
      v_pos_q       <= '0;
      vs_lines      <= '0;
      vs_hi         <= 1'b0;
      armed         <= 1'b0;
      flag_en       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      h_pos_q <= ls_c ? '0 : h_pos_q + pos_t'(1);

      if (realign_c)  v_pos_q <= '0;
      else if (ls_c)  v_pos_q <= v_end ? '0 : v_pos_q + pos_t'(1);

      if (realign_c)    armed <= 1'b0;
      else if (vs_rise) armed <= 1'b1;

      vs_hi <= vs_lvl;
      if (vs_fall)                            vs_lines <= '0;
      else if (vs_lvl && ls_c && vs_lines != '1) vs_lines <= vs_lines + pos_t'(1);

      flag_en       <= flag_en | realign_c;
      line_start_q  <= ls_c;
      frame_start_q <= realign_c;
      sync_err_q    <= err_c;
      if (err_c && err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + err_cnt_t'(1);
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
      locked_q <= 1'b0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_nx;
      locked_q <= (state_nx == LOCKED);  // drops on the same edge as sync_err
    end
  end

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    case (state)
      SEARCH: if (realign_c && !err_c) begin
        state_nx = ACQUIRE;
        good_nx  = '0;
      end
      ACQUIRE: begin
        if (err_c) state_nx = SEARCH;
        else if (realign_c) begin
          good_nx = good_cnt + 8'd1;
          if (good_cnt + 8'd1 >= LOCK_N) state_nx = LOCKED;
        end
      end
      LOCKED:  if (err_c) state_nx = SEARCH;
      default: state_nx = SEARCH;
    endcase
  end

  assign bus.h_pos       = h_pos_q;
  assign bus.v_pos       = v_pos_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.locked      = locked_q;
endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx with reduced geometry (40x12, hs 6, vs 2 lines).
module tb_vga_sync_rx;
  localparam int H_T = 40, V_T = 12, H_P = 6, V_P = 2, LF = 2;

  logic clk_25 = 1'b0;
  logic rst_n  = 1'b0;
  always #20 clk_25 = ~clk_25;

  vga_sync_rx_if bus();

  vga_sync_rx #(.H_TOTAL(H_T), .V_TOTAL(V_T), .H_PULSE(H_P), .V_PULSE(V_P), .LOCK_FRAMES(LF))
    dut (.clk_25(clk_25), .rst_n(rst_n), .bus(bus));

  typedef struct {int cyc; int v; bit fs;} exp_t;
  exp_t sbq[$];
  exp_t e;
  int   cyc = 0, n_checks = 0, n_fail = 0, err_pulses = 0, v_model = 0, last_ls_cyc = 0;
  bit   vs_prev = 1'b0;
  logic [9:0] ls_hpos, ls_vpos;
  logic       ls_locked, ls_serr;
  logic [9:0] ln_hpos[V_T], ln_vpos[V_T];
  logic       ln_locked[V_T], ln_serr[V_T];

  always @(posedge clk_25) cyc <= cyc + 1;

  // Scoreboard: every line start the stimulus predicts must appear exactly
  // two clocks after its hs rise, with h_pos=0 and the modelled v_pos.
  always @(negedge clk_25) begin
    if (rst_n) begin
      if (bus.sync_err) err_pulses++;
      if (bus.line_start) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: line_start at cyc %0d, none required", cyc);
        end else begin
          e = sbq.pop_front();
          if (cyc !== e.cyc || bus.h_pos !== 10'd0 || bus.v_pos !== 10'(e.v) || bus.frame_start !== e.fs) begin
            n_fail++;
            $display("FAIL sb_line: got cyc=%0d h_pos=%0d v_pos=%0d fs=%0b, required cyc=%0d h_pos=0 v_pos=%0d fs=%0b",
                     cyc, bus.h_pos, bus.v_pos, bus.frame_start, e.cyc, e.v, e.fs);
          end
        end
      end else if (bus.frame_start) begin
        n_checks++; n_fail++;
        $display("FAIL sb_fs_alone: frame_start=1 without line_start at cyc %0d, required 0", cyc);
      end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        n_checks++; n_fail++;
        e = sbq.pop_front();
        $display("FAIL sb_missed: no line_start by cyc %0d, required at cyc %0d", cyc, e.cyc);
      end
    end
  end

  initial begin
    #8000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // One line: hs high for hs_w clocks from the line start, vs level for the line.
  task automatic drive_line(input int len, input bit do_hs, input bit vs_lvl, input int hs_w);
    exp_t x;
    for (int i = 0; i < len; i++) begin
      @(negedge clk_25);
      if (i == 0) begin
        bus.vs = vs_lvl;
        x.cyc  = cyc + 2;
        if (vs_lvl && !vs_prev) begin v_model = 0; x.fs = 1'b1; end
        else begin v_model = (v_model + 1) % V_T; x.fs = 1'b0; end
        x.v = v_model;
        sbq.push_back(x);
        last_ls_cyc = cyc + 2;
        vs_prev = vs_lvl;
      end
      bus.hs = do_hs && (i < hs_w);
      if (i == 2) begin
        ls_hpos = bus.h_pos; ls_vpos = bus.v_pos; ls_locked = bus.locked; ls_serr = bus.sync_err;
      end
    end
  endtask

  task automatic drive_frame(input int short_ln, input int skip_ln, input int vs_n);
    for (int l = 0; l < V_T; l++) begin
      drive_line((l == short_ln) ? H_T - 1 : H_T, l != skip_ln, l < vs_n, H_P);
      ln_hpos[l] = ls_hpos; ln_vpos[l] = ls_vpos; ln_locked[l] = ls_locked; ln_serr[l] = ls_serr;
    end
  endtask

  task automatic test_reset;
    bus.hs = 1'b0; bus.vs = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk_25);
    n_checks++;
    if ({bus.h_pos, bus.v_pos, bus.line_start, bus.frame_start, bus.sync_err, bus.err_cnt, bus.locked} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_state: h=%0d v=%0d ls=%0b fs=%0b se=%0b ec=%0d lk=%0b, required all 0",
               bus.h_pos, bus.v_pos, bus.line_start, bus.frame_start, bus.sync_err, bus.err_cnt, bus.locked);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_nominal;
    int base = err_pulses;
    for (int f = 0; f < 4; f++) begin
      drive_frame(-1, -1, V_P);
      n_checks++;
      if (ln_locked[0] !== (f >= 2)) begin
        n_fail++; $display("FAIL nominal_lock f%0d: locked=%0b, required %0b", f, ln_locked[0], f >= 2);
      end
    end
    n_checks++;
    if (err_pulses - base != 0) begin n_fail++; $display("FAIL nominal_err: %0d sync_err, required 0", err_pulses - base); end
    n_checks++;
    if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL nominal_errcnt: %0d, required 0", bus.err_cnt); end
  endtask

  task automatic test_short_line;
    int base = err_pulses;
    drive_frame(5, -1, V_P);
    n_checks++;
    if (ln_serr[6] !== 1'b1 || ln_locked[6] !== 1'b0) begin
      n_fail++; $display("FAIL short_edge: sync_err=%0b locked=%0b, required 1 0", ln_serr[6], ln_locked[6]);
    end
    n_checks++;
    if (err_pulses - base != 1) begin n_fail++; $display("FAIL short_err: %0d sync_err, required 1", err_pulses - base); end
    n_checks++;
    if (bus.err_cnt !== 8'd1 || bus.locked !== 1'b0) begin
      n_fail++; $display("FAIL short_state: err_cnt=%0d locked=%0b, required 1 0", bus.err_cnt, bus.locked);
    end
    for (int f = 0; f < 3; f++) begin
      drive_frame(-1, -1, V_P);
      n_checks++;
      if (ln_locked[0] !== (f == 2)) begin
        n_fail++; $display("FAIL short_relock f%0d: locked=%0b, required %0b", f, ln_locked[0], f == 2);
      end
    end
  endtask

  task automatic test_missing_hs;
    int base = err_pulses;
    drive_frame(-1, 5, V_P);
    n_checks++;
    if (ln_hpos[5] !== 10'd0 || ln_vpos[5] !== 10'd5 || ln_serr[5] !== 1'b1) begin
      n_fail++; $display("FAIL miss_wrap: h_pos=%0d v_pos=%0d sync_err=%0b, required 0 5 1", ln_hpos[5], ln_vpos[5], ln_serr[5]);
    end
    n_checks++;
    if (err_pulses - base != 1) begin n_fail++; $display("FAIL miss_err: %0d sync_err, required 1", err_pulses - base); end
    n_checks++;
    if (bus.err_cnt !== 8'd2 || bus.locked !== 1'b0) begin
      n_fail++; $display("FAIL miss_state: err_cnt=%0d locked=%0b, required 2 0", bus.err_cnt, bus.locked);
    end
    for (int f = 0; f < 3; f++) begin
      drive_frame(-1, -1, V_P);
      n_checks++;
      if (ln_locked[0] !== (f == 2)) begin
        n_fail++; $display("FAIL miss_relock f%0d: locked=%0b, required %0b", f, ln_locked[0], f == 2);
      end
    end
  endtask

  task automatic test_wide_vs;
    int base = err_pulses;
    drive_frame(-1, -1, 3);
    n_checks++;
    if (ln_locked[2] !== 1'b1 || ln_serr[3] !== 1'b1 || ln_locked[3] !== 1'b0) begin
      n_fail++; $display("FAIL vs_fall: locked2=%0b sync_err3=%0b locked3=%0b, required 1 1 0", ln_locked[2], ln_serr[3], ln_locked[3]);
    end
    n_checks++;
    if (err_pulses - base != 1 || bus.err_cnt !== 8'd3) begin
      n_fail++; $display("FAIL vs_err: pulses=%0d err_cnt=%0d, required 1 3", err_pulses - base, bus.err_cnt);
    end
    for (int f = 0; f < 3; f++) begin
      drive_frame(-1, -1, V_P);
      n_checks++;
      if (ln_locked[0] !== (f == 2)) begin
        n_fail++; $display("FAIL vs_relock f%0d: locked=%0b, required %0b", f, ln_locked[0], f == 2);
      end
    end
  endtask

  task automatic test_reset_mid;
    int base, exp_h;
    for (int l = 0; l < 6; l++) drive_line(H_T, 1'b1, l < V_P, H_P);
    drive_line(H_T / 2, 1'b1, 1'b0, H_P);
    #1;
    exp_h = cyc - last_ls_cyc;
    n_checks++;
    if (bus.h_pos !== 10'(exp_h) || bus.v_pos !== 10'd6 || bus.locked !== 1'b1 || bus.err_cnt !== 8'd3) begin
      n_fail++; $display("FAIL mid_pre: h=%0d v=%0d locked=%0b err_cnt=%0d, required %0d 6 1 3",
                         bus.h_pos, bus.v_pos, bus.locked, bus.err_cnt, exp_h);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.h_pos, bus.v_pos, bus.line_start, bus.frame_start, bus.sync_err, bus.err_cnt, bus.locked} !== 33'd0) begin
      n_fail++; $display("FAIL mid_async: h=%0d v=%0d ls=%0b fs=%0b se=%0b ec=%0d lk=%0b, required all 0",
                         bus.h_pos, bus.v_pos, bus.line_start, bus.frame_start, bus.sync_err, bus.err_cnt, bus.locked);
    end
    repeat (2) @(negedge clk_25);
    sbq.delete(); v_model = 0; vs_prev = 1'b0; bus.hs = 1'b0; bus.vs = 1'b0;
    rst_n = 1'b1;
    base = err_pulses;
    for (int f = 0; f < 3; f++) begin
      drive_frame(-1, -1, V_P);
      n_checks++;
      if (ln_locked[0] !== (f == 2)) begin
        n_fail++; $display("FAIL mid_relock f%0d: locked=%0b, required %0b", f, ln_locked[0], f == 2);
      end
    end
    n_checks++;
    if (err_pulses - base != 0 || bus.err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL mid_clean: pulses=%0d err_cnt=%0d, required 0 0", err_pulses - base, bus.err_cnt);
    end
  endtask

  task automatic test_err_sat;
    int base;
    @(negedge clk_25);
    rst_n = 1'b0; bus.hs = 1'b0; bus.vs = 1'b0;
    @(negedge clk_25);
    sbq.delete(); v_model = 0; vs_prev = 1'b0;
    rst_n = 1'b1;
    base = err_pulses;
    drive_line(H_T, 1'b1, 1'b1, H_P);
    // Each 20-clock line after the first one ends early: one error per line.
    for (int n = 1; n <= 300; n++) begin
      drive_line(20, 1'b1, n == 1, H_P);
      if (n == 200) begin
        n_checks++;
        if (bus.err_cnt !== 8'd199) begin n_fail++; $display("FAIL sat_mid: err_cnt=%0d, required 199", bus.err_cnt); end
      end
      if (n == 270) begin
        n_checks++;
        if (bus.err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold: err_cnt=%0d, required 255", bus.err_cnt); end
      end
    end
    n_checks++;
    if (bus.err_cnt !== 8'd255 || err_pulses - base != 299 || bus.locked !== 1'b0) begin
      n_fail++; $display("FAIL sat_end: err_cnt=%0d pulses=%0d locked=%0b, required 255 299 0",
                         bus.err_cnt, err_pulses - base, bus.locked);
    end
  endtask

  initial begin
    bus.hs = 1'b0;
    bus.vs = 1'b0;
    test_reset;
    test_nominal;
    test_short_line;
    test_missing_hs;
    test_wide_vs;
    test_reset_mid;
    test_err_sat;
    repeat (4) @(negedge clk_25);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
